// File: rtl/pwm_width_capture.sv
// pwm_width_capture: measures PWM high time in XCK ticks per LDL-delimited frame.
module pwm_width_capture #(
   parameter int SYNC_STAGES = 2,
   parameter int PERIOD_MAX  = 128
) (
   input  logic       MasterClock,
   input  logic       ResetL,
   input  logic       XCK,
   input  logic       LDL,
   input  logic       PW,
   output logic [6:0] WIDTH,
   output logic       VALID,
   output logic       OVF,
   output logic       TIMEOUT
);
   localparam int PER_W = $clog2(PERIOD_MAX + 1);
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_MAX - 1);
   localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t           r_state;
   logic [6:0]       r_cnt;
   logic             r_ovf_f;
   logic [PER_W-1:0] r_per;
   logic [6:0]       r_width;
   logic             r_valid;
   logic             r_ovf;
   logic             r_timeout;
   logic             w_pw_s;
   logic             w_start;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_pw_s = PW;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync;
         // PW shift chain into the MasterClock domain
         always_ff @(posedge MasterClock or negedge ResetL) begin
            if (!ResetL) begin
               r_sync <= '0;
            end else begin
               r_sync[0] <= PW;
               for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            end
         end
         assign w_pw_s = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   assign w_start = XCK & ~LDL;

   // frame FSM: count high ticks, publish on the next start, give up after PERIOD_MAX ticks
   always_ff @(posedge MasterClock or negedge ResetL) begin
      if (!ResetL) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_ovf_f   <= 1'b0;
         r_per     <= '0;
         r_width   <= '0;
         r_valid   <= 1'b0;
         r_ovf     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         if (w_start) begin
            if (r_state == MEASURE) begin
               r_width <= r_cnt;
               r_ovf   <= r_ovf_f;
               r_valid <= 1'b1;
            end
            r_cnt   <= {6'd0, w_pw_s};
            r_ovf_f <= 1'b0;
            r_per   <= PER_ONE;
            r_state <= MEASURE;
         end else if (XCK && r_state == MEASURE) begin
            if (r_per == PER_LAST) begin
               r_timeout <= 1'b1;
               r_state   <= IDLE;
               r_cnt     <= '0;
               r_ovf_f   <= 1'b0;
               r_per     <= '0;
            end else begin
               r_per <= r_per + PER_ONE;
               if (w_pw_s) begin
                  if (r_cnt == 7'd127) r_ovf_f <= 1'b1;
                  else r_cnt <= r_cnt + 7'd1;
               end
            end
         end
      end
   end

   assign WIDTH   = r_width;
   assign VALID   = r_valid;
   assign OVF     = r_ovf;
   assign TIMEOUT = r_timeout;
endmodule

// File: tb/tb_pwm_width_capture.sv
// tb_pwm_width_capture: directed checks of pulse width capture across three parameter sets.
module tb_pwm_width_capture;
   logic       MasterClock = 1'b0;
   logic       ResetL = 1'b0;
   logic       XCK = 1'b0;
   logic       LDL = 1'b1;
   logic       PW = 1'b0;
   logic [6:0] w_width [3];
   logic       w_valid [3];
   logic       w_ovf [3];
   logic       w_to [3];
   int         n_tot = 0;
   int         n_pass = 0;
   int         vcnt [3] = '{0, 0, 0};
   string      phase = "init";

   // instance 0: no sync, PERIOD_MAX 128; 1: no sync, 200; 2: 2-stage sync, 128
   pwm_width_capture #(.SYNC_STAGES(0), .PERIOD_MAX(128)) u0 (
      .MasterClock(MasterClock), .ResetL(ResetL), .XCK(XCK), .LDL(LDL), .PW(PW),
      .WIDTH(w_width[0]), .VALID(w_valid[0]), .OVF(w_ovf[0]), .TIMEOUT(w_to[0]));
   pwm_width_capture #(.SYNC_STAGES(0), .PERIOD_MAX(200)) u1 (
      .MasterClock(MasterClock), .ResetL(ResetL), .XCK(XCK), .LDL(LDL), .PW(PW),
      .WIDTH(w_width[1]), .VALID(w_valid[1]), .OVF(w_ovf[1]), .TIMEOUT(w_to[1]));
   pwm_width_capture #(.SYNC_STAGES(2), .PERIOD_MAX(128)) u2 (
      .MasterClock(MasterClock), .ResetL(ResetL), .XCK(XCK), .LDL(LDL), .PW(PW),
      .WIDTH(w_width[2]), .VALID(w_valid[2]), .OVF(w_ovf[2]), .TIMEOUT(w_to[2]));

   always #5 MasterClock = ~MasterClock;

   // count VALID-high cycles so pulse length and frequency can be checked
   always @(negedge MasterClock) for (int i = 0; i < 3; i++) vcnt[i] += int'(w_valid[i]);

   task automatic check(input string tag, input int got, input int exp);
      n_tot++;
      if (got !== exp) $display("FAIL %s/%s got=%0d exp=%0d", phase, tag, got, exp);
      else n_pass++;
   endtask

   task automatic cyc(input logic x, input logic l, input logic p);
      XCK = x;
      LDL = l;
      PW  = p;
      @(posedge MasterClock);
      #1;
   endtask

   task automatic do_reset();
      ResetL = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, i[1], i[0]);
         check("rst0", int'({w_width[0], w_valid[0], w_ovf[0], w_to[0]}), 0);
         check("rst2", int'({w_width[2], w_valid[2], w_ovf[2], w_to[2]}), 0);
      end
      ResetL = 1'b1;
      cyc(1'b1, 1'b1, 1'b0);
      check("post_rst", int'({w_width[0], w_valid[0], w_ovf[0], w_to[0]}), 0);
   endtask

   // one frame: start tick then ticks-1 ticks, PW high on the first 'high' ticks,
   // div-1 non-tick cycles after every tick with PW=pwi
   task automatic run_frame(input int idx, input int ticks, input int high, input int div,
                            input logic pwi, input logic chk, input int ew, input int eo);
      for (int t = 0; t < ticks; t++) begin
         cyc(1'b1, t != 0, t < high);
         if (t == 0) begin
            check("valid", int'(w_valid[idx]), int'(chk));
            check("no_tmo", int'(w_to[idx]), 0);
            if (chk) begin
               check("width", int'(w_width[idx]), ew);
               check("ovf", int'(w_ovf[idx]), eo);
            end
         end
         for (int d = 1; d < div; d++) cyc(1'b0, 1'b1, pwi);
      end
   endtask

   initial begin
      int v0;
      phase = "reset";
      do_reset();

      phase = "basic";
      run_frame(0, 100, 40, 1, 1'b0, 1'b0, 0, 0);
      v0 = vcnt[0];
      run_frame(0, 100, 40, 1, 1'b0, 1'b1, 40, 0);
      run_frame(0, 100, 0, 1, 1'b0, 1'b1, 40, 0);
      run_frame(0, 100, 25, 1, 1'b0, 1'b1, 0, 0);
      check("valid_count", vcnt[0] - v0, 3);

      phase = "slow_xck";
      run_frame(0, 100, 40, 3, 1'b1, 1'b1, 25, 0);
      run_frame(0, 100, 40, 3, 1'b1, 1'b1, 40, 0);

      phase = "saturate";
      run_frame(0, 127, 127, 1, 1'b0, 1'b1, 40, 0);
      run_frame(0, 127, 127, 1, 1'b0, 1'b1, 127, 0);
      run_frame(1, 150, 150, 1, 1'b0, 1'b1, 127, 0);
      run_frame(1, 150, 150, 1, 1'b0, 1'b1, 127, 1);
      run_frame(1, 1, 0, 1, 1'b0, 1'b1, 127, 1);

      phase = "timeout";
      repeat (126) cyc(1'b1, 1'b1, 1'b1);
      check("tmo_early", int'(w_to[0]), 0);
      cyc(1'b1, 1'b1, 1'b1);
      check("tmo", int'(w_to[0]), 1);
      check("tmo_width", int'(w_width[0]), 127);
      check("tmo_ovf", int'(w_ovf[0]), 0);
      check("tmo_valid", int'(w_valid[0]), 0);
      cyc(1'b1, 1'b1, 1'b0);
      check("tmo_pulse", int'(w_to[0]), 0);
      run_frame(0, 50, 10, 1, 1'b0, 1'b0, 0, 0);
      run_frame(0, 50, 0, 1, 1'b0, 1'b1, 10, 0);

      phase = "one_tick";
      run_frame(0, 1, 1, 1, 1'b0, 1'b1, 0, 0);
      run_frame(0, 1, 0, 1, 1'b0, 1'b1, 1, 0);
      run_frame(0, 1, 0, 1, 1'b0, 1'b1, 0, 0);

      phase = "sync_reset";
      do_reset();
      run_frame(2, 40, 20, 1, 1'b0, 1'b0, 0, 0);
      do_reset();
      run_frame(2, 60, 20, 1, 1'b0, 1'b0, 0, 0);
      run_frame(2, 60, 30, 1, 1'b0, 1'b1, 20, 0);
      run_frame(2, 60, 59, 1, 1'b0, 1'b1, 30, 0);
      run_frame(2, 60, 0, 1, 1'b0, 1'b1, 58, 0);
      run_frame(2, 60, 0, 1, 1'b0, 1'b1, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
